div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage initiator for the multicycle divider. Drives the divider's start/cancel/operand inputs and consumes its 64-bit result and one-cycle success pulse.
- Stalls the pipeline while a DIV/DIVU is in flight and writes the quotient and remainder into HI/LO.
- Handles flush/cancel, including draining any late success pulse that arrives after a cancel.

Parameters:
- DRAIN_CYCLES, 3: cycles that cancel is held and the divider's ready is ignored after a flush; this covers the ZERO->END->FREE success pulse.
- TIMEOUT_CYCLES, 40: watchdog limit in BUSY; used only when DIV_ISSUE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- div_req_i  in  1  EX instruction is DIV/DIVU
- div_signed_i  in  1  1=DIV, 0=DIVU
- opdata1_i  in  32  dividend from EX
- opdata2_i  in  32  divisor from EX
- flush_i  in  1  pipeline flush/exception; kills the in-flight divide
- ex_hold_i  in  1  stall from a later stage; EX cannot retire this cycle
- div_result_i  in  64  divider result, {remainder[63:32], quotient[31:0]}
- div_ready_i  in  1  divider success pulse
- div_start_o  out  1  divider start
- div_signed_o  out  1  divider signed select
- div_opdata1_o  out  32  latched dividend
- div_opdata2_o  out  32  latched divisor
- div_cancel_o  out  1  divider cancel
- stall_req_o  out  1  stall request to pipeline control
- hilo_we_o  out  1  HI/LO write enable
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- timeout_o  out  1  watchdog fired; sticky until reset; tied 0 when the feature is compiled out

Behaviour:
- Reset: state=IDLE; all registered outputs, operand latches, result latch and counters are 0. A reset mid-divide abandons the operation with no HI/LO write; the divider shares rst.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - If div_req_i & ~flush_i: latch operands and signed, go to BUSY.
  - stall_req_o=1 combinationally in this cycle.
  - div_ready_i is ignored.
- BUSY:
  - div_start_o = ~div_ready_i & ~flush_i, combinational. Start must drop in the same cycle ready is seen, because the divider is already back in FREE and would otherwise restart.
  - Operands are driven only from the latches, never from the live EX inputs.
  - stall_req_o=1.
  - On div_ready_i: capture hi=result[63:32], lo=result[31:0], go to DONE.
- DONE:
  - stall_req_o=0.
  - When ~ex_hold_i: hilo_we_o=1 for exactly one cycle with the captured hi_o/lo_o, then go to IDLE.
  - While ex_hold_i: stay in DONE, hold the result, hilo_we_o=0, no reissue even if div_req_i is high.
- Flush:
  - flush_i in BUSY or DONE: no HI/LO write, div_start_o=0 that cycle, go to DRAIN.
  - flush_i in IDLE: no issue.
- DRAIN:
  - div_cancel_o=1 and div_start_o=0 for DRAIN_CYCLES cycles, counted by a down-counter.
  - div_ready_i is ignored.
  - stall_req_o=0.
  - Exit to IDLE. A div_req_i arriving during DRAIN waits in IDLE, so it is stalled via the IDLE stall term.
- Flush has priority over a simultaneous div_ready_i: the result is discarded.
- Divide by zero: the divider returns 0/0 with success. This block writes HI=LO=0 like a normal result; no exception is raised.
- Latency: 1 (issue) + divider latency + 1 (write). Back-to-back DIVs are supported, with one IDLE cycle between them.

Optional Feature:
- DIV_ISSUE_TIMEOUT_EN:
  - Defined: an 8-bit counter runs in BUSY. When it reaches TIMEOUT_CYCLES without ready, the block sets timeout_o (sticky), writes nothing, and goes to DRAIN (cancel asserted).
  - Undefined: no counter; BUSY waits indefinitely; timeout_o=0.

Decomposition:
- Shared package div_pkg:
  - state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10, DRAIN=2'b11)
  - DIV_RES_W=64
  - HI/LO field slice constants
- No sub-module is needed. The drain/watchdog counter is inline.

Test Plan:
- DIVU 100/7, no hold -> stall high until ready, start drops the same cycle, then hilo_we one cycle with hi=2, lo=14; divider does not restart.
- DIV -7/2 (0xFFFFFFF9 / 2) -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- DIVU 5/0 -> hilo_we once with hi=0, lo=0; no second start.
- Flush 10 cycles into a 100/7 divide -> cancel high for 3 cycles, no hilo_we, the divider's late success ignored; a following DIVU 9/3 gives hi=0, lo=3.
- ex_hold_i high for 4 cycles after ready -> hilo_we stays 0, hi/lo stable, no restart; single write on the cycle hold drops.
- Reset asserted mid-BUSY -> all outputs 0 next cycle, no write. With DIV_ISSUE_TIMEOUT_EN and a divider model that never responds: timeout_o=1 after 40 BUSY cycles, then the DRAIN sequence runs.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider issue controller: state encoding,
// result width and HI/LO field positions within the divider result word.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_DRAIN = 2'b11
    } div_state_e;

    localparam int DIV_OP_W  = 32;
    localparam int DIV_RES_W = 64;
    localparam int LO_LSB    = 0;
    localparam int LO_MSB    = 31;
    localparam int HI_LSB    = 32;
    localparam int HI_MSB    = 63;
    localparam int CNT_W     = 8;

    function automatic logic [DIV_OP_W-1:0] res_hi(input logic [DIV_RES_W-1:0] res);
        return res[HI_MSB:HI_LSB];
    endfunction

    function automatic logic [DIV_OP_W-1:0] res_lo(input logic [DIV_RES_W-1:0] res);
        return res[LO_MSB:LO_LSB];
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the issue controller (master) and the multicycle
// divider (slave): start/cancel/operands out, result and success pulse back.
interface div_issue_ctrl_if;
    import div_pkg::*;

    logic                 div_start_o;
    logic                 div_signed_o;
    logic [DIV_OP_W-1:0]  div_opdata1_o;
    logic [DIV_OP_W-1:0]  div_opdata2_o;
    logic                 div_cancel_o;
    logic [DIV_RES_W-1:0] div_result_i;
    logic                 div_ready_i;

    modport master (
        output div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o, div_cancel_o,
        input  div_result_i, div_ready_i
    );

    modport slave (
        input  div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o, div_cancel_o,
        output div_result_i, div_ready_i
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage DIV/DIVU initiator: issues to the divider, stalls EX, writes HI/LO,
// and drains after flush. Optional BUSY watchdog under `DIV_ISSUE_TIMEOUT_EN.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_req_i,
    input  logic                div_signed_i,
    input  logic [DIV_OP_W-1:0] opdata1_i,
    input  logic [DIV_OP_W-1:0] opdata2_i,
    input  logic                flush_i,
    input  logic                ex_hold_i,
    div_issue_ctrl_if.master    div_if,
    output logic                stall_req_o,
    output logic                hilo_we_o,
    output logic [DIV_OP_W-1:0] hi_o,
    output logic [DIV_OP_W-1:0] lo_o,
    output logic                timeout_o
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef DIV_ISSUE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_OP_W-1:0] op1_q, op1_d;
    logic [DIV_OP_W-1:0] op2_q, op2_d;
    logic [DIV_OP_W-1:0] hi_q, hi_d;
    logic [DIV_OP_W-1:0] lo_q, lo_d;
    logic                sgn_q, sgn_d;
    logic                tmo_q, tmo_d;
    logic                tmo_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        op1_d               = op1_q;
        op2_d               = op2_q;
        hi_d                = hi_q;
        lo_d                = lo_q;
        sgn_d               = sgn_q;
        tmo_d               = tmo_q;
        tmo_fire            = 1'b0;
        div_if.div_start_o  = 1'b0;
        div_if.div_cancel_o = 1'b0;
        stall_req_o         = 1'b0;
        hilo_we_o           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (div_req_i && !flush_i) begin
                    stall_req_o = 1'b1;
                    op1_d       = opdata1_i;
                    op2_d       = opdata2_i;
                    sgn_d       = div_signed_i;
                    cnt_d       = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_req_o = 1'b1;
                tmo_fire    = TMO_EN && (cnt_q == TMO_LAST);
                // Flush beats a same-cycle success; start must fall with ready
                // because the divider is already free again in that cycle.
                if (flush_i) begin
                    cnt_d   = DRAIN_LOAD;
                    state_d = ST_DRAIN;
                end else if (div_if.div_ready_i) begin
                    hi_d    = res_hi(div_if.div_result_i);
                    lo_d    = res_lo(div_if.div_result_i);
                    state_d = ST_DONE;
                end else if (tmo_fire) begin
                    tmo_d   = 1'b1;
                    cnt_d   = DRAIN_LOAD;
                    state_d = ST_DRAIN;
                end else begin
                    div_if.div_start_o = 1'b1;
                    if (TMO_EN) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    cnt_d   = DRAIN_LOAD;
                    state_d = ST_DRAIN;
                end else if (!ex_hold_i) begin
                    hilo_we_o = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Cancel covers the divider's late success pulse, which is ignored here.
                div_if.div_cancel_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign div_if.div_signed_o  = sgn_q;
    assign div_if.div_opdata1_o = op1_q;
    assign div_if.div_opdata2_o = op2_q;
    assign hi_o                 = hi_q;
    assign lo_o                 = lo_q;
    assign timeout_o            = tmo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: divider model, per-cycle reference model and directed tests.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req, div_signed, flush, ex_hold;
    logic [31:0] op1, op2;
    logic        stall, hilo_we, timeout;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

`ifdef DIV_ISSUE_TIMEOUT_EN
    localparam bit TB_TMO = 1'b1;
`else
    localparam bit TB_TMO = 1'b0;
`endif

    div_issue_ctrl_if dif();

    div_issue_ctrl #(.DRAIN_CYCLES(3), .TIMEOUT_CYCLES(40)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req_i    (div_req),
        .div_signed_i (div_signed),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .flush_i      (flush),
        .ex_hold_i    (ex_hold),
        .div_if       (dif),
        .stall_req_o  (stall),
        .hilo_we_o    (hilo_we),
        .hi_o         (hi),
        .lo_o         (lo),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = a; sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    // Divider model: accepts start when free, succeeds after dv_lat cycles,
    // and emits one late success pulse after being cancelled mid-operation.
    int          dv_lat = 8;
    bit          dv_never = 1'b0;
    int          n_starts = 0;
    int          dv_cnt;
    logic        dv_busy, dv_late;
    logic [63:0] dv_res;

    always @(posedge clk) begin
        if (rst) begin
            dv_busy          <= 1'b0;
            dv_late          <= 1'b0;
            dv_cnt           <= 0;
            dif.div_ready_i  <= 1'b0;
            dif.div_result_i <= '0;
        end else begin
            dif.div_ready_i <= 1'b0;
            if (dv_late) begin
                dif.div_ready_i  <= 1'b1;
                dif.div_result_i <= dv_res;
                dv_late          <= 1'b0;
            end else if (dv_busy) begin
                if (dif.div_cancel_o) begin
                    dv_busy <= 1'b0;
                    dv_late <= 1'b1;
                end else if (!dv_never && dv_cnt == 0) begin
                    dif.div_ready_i  <= 1'b1;
                    dif.div_result_i <= dv_res;
                    dv_busy          <= 1'b0;
                end else if (dv_cnt > 0) begin
                    dv_cnt <= dv_cnt - 1;
                end
            end else if (dif.div_start_o && !dif.div_cancel_o) begin
                dv_busy  <= 1'b1;
                dv_cnt   <= dv_lat - 1;
                dv_res   <= ref_div(dif.div_signed_o, dif.div_opdata1_o, dif.div_opdata2_o);
                n_starts <= n_starts + 1;
            end
        end
    end

    // Reference model: tracks whether a divide is outstanding, a result is
    // waiting to retire, or a post-flush drain window is open.
    bit          m_wait, m_have, m_tmo;
    int          m_drain, m_bcnt;
    logic [31:0] m_op1, m_op2, m_hi, m_lo;
    logic        m_sg;
    int          n_we = 0;
    bit          e_idle, e_tfire, e_start, e_stall, e_we, e_cancel;

    always @(negedge clk) begin
        if (chk_en) begin
            e_idle   = !m_wait && !m_have && (m_drain == 0);
            e_tfire  = TB_TMO && m_wait && (m_bcnt == 39) && !dif.div_ready_i && !flush;
            e_start  = m_wait && !dif.div_ready_i && !flush && !e_tfire;
            e_stall  = m_wait || (e_idle && div_req && !flush);
            e_we     = m_have && !ex_hold && !flush;
            e_cancel = (m_drain != 0);
            chk("start",   32'(dif.div_start_o),  32'(e_start));
            chk("cancel",  32'(dif.div_cancel_o), 32'(e_cancel));
            chk("stall",   32'(stall),            32'(e_stall));
            chk("hilo_we", 32'(hilo_we),          32'(e_we));
            chk("hi",      hi,                    m_hi);
            chk("lo",      lo,                    m_lo);
            chk("opdata1", dif.div_opdata1_o,     m_op1);
            chk("opdata2", dif.div_opdata2_o,     m_op2);
            chk("signed",  32'(dif.div_signed_o), 32'(m_sg));
            chk("timeout", 32'(timeout),          32'(m_tmo));
            if (hilo_we === 1'b1) n_we++;

            if (rst) begin
                m_wait = 0; m_have = 0; m_tmo = 0; m_drain = 0; m_bcnt = 0;
                m_op1 = '0; m_op2 = '0; m_hi = '0; m_lo = '0; m_sg = 1'b0;
            end else if (m_drain != 0) begin
                m_drain--;
            end else if (m_wait) begin
                if (flush) begin
                    m_wait = 0; m_drain = 3;
                end else if (dif.div_ready_i) begin
                    m_wait = 0; m_have = 1;
                    m_hi = dif.div_result_i[63:32];
                    m_lo = dif.div_result_i[31:0];
                end else if (e_tfire) begin
                    m_wait = 0; m_tmo = 1; m_drain = 3;
                end else begin
                    m_bcnt++;
                end
            end else if (m_have) begin
                if (flush) begin
                    m_have = 0; m_drain = 3;
                end else if (!ex_hold) begin
                    m_have = 0;
                end
            end else if (div_req && !flush) begin
                m_wait = 1; m_bcnt = 0;
                m_op1 = op1; m_op2 = op2; m_sg = div_signed;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input int hold_n);
        int we0, st0, rcyc, wcyc, scyc, hl;
        bit rseen, wseen;
        we0 = n_we; st0 = n_starts;
        rcyc = -1; wcyc = -1; scyc = -1; hl = hold_n;
        rseen = 0; wseen = 0;
        div_signed = sg; op1 = a; op2 = b; div_req = 1'b1; ex_hold = (hold_n > 0);
        for (int c = 0; c < 200 && !wseen; c++) begin
            @(negedge clk);
            if (dif.div_start_o === 1'b1 && scyc < 0) scyc = c;
            if (dif.div_ready_i === 1'b1 && !rseen) begin
                rseen = 1; rcyc = c;
            end
            if (hilo_we === 1'b1) begin
                wseen = 1; wcyc = c;
                chk({nm, "_hi"}, hi, ehi);
                chk({nm, "_lo"}, lo, elo);
            end
            tick();
            if (rseen && ex_hold) begin
                if (hl == 0) ex_hold = 1'b0;
                else hl--;
            end
        end
        div_req = 1'b0; ex_hold = 1'b0;
        if (!wseen) chk({nm, "_nowrite"}, 32'd0, 32'd1);
        chk({nm, "_start_lat"}, 32'(scyc), 32'd1);
        chk({nm, "_wr_lat"}, 32'(wcyc - rcyc), 32'(hold_n + 1));
        repeat (3) tick();
        chk({nm, "_n_we"}, 32'(n_we - we0), 32'd1);
        chk({nm, "_n_start"}, 32'(n_starts - st0), 32'd1);
    endtask

    initial begin
        int cc, lr, tcyc, we0;
        rst = 1'b1; div_req = 1'b0; div_signed = 1'b0; op1 = '0; op2 = '0;
        flush = 1'b0; ex_hold = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_start",  32'(dif.div_start_o),  32'd0);
        chk("rst_cancel", 32'(dif.div_cancel_o), 32'd0);
        chk("rst_stall",  32'(stall),            32'd0);
        chk("rst_we",     32'(hilo_we),          32'd0);
        chk("rst_hi",     hi,                    32'd0);
        chk("rst_lo",     lo,                    32'd0);
        chk("rst_tmo",    32'(timeout),          32'd0);
        rst = 1'b0;
        tick();

        dv_lat = 8;
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 0);

        // Flush ten cycles into a long divide.
        we0 = n_we;
        dv_lat = 34;
        div_signed = 1'b0; op1 = 32'd100; op2 = 32'd7; div_req = 1'b1;
        repeat (11) tick();
        flush = 1'b1; div_req = 1'b0;
        tick();
        flush = 1'b0;
        cc = 0; lr = 0;
        repeat (8) begin
            @(negedge clk);
            if (dif.div_cancel_o === 1'b1) cc++;
            if (dif.div_ready_i === 1'b1) lr++;
            tick();
        end
        chk("flush_cancel_cycles", 32'(cc), 32'd3);
        chk("flush_late_ready", 32'(lr), 32'd1);
        chk("flush_no_we", 32'(n_we - we0), 32'd0);
        dv_lat = 8;
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0);

        run_div("hold4_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 4);

        // Divider never answers.
        dv_never = 1'b1;
        div_signed = 1'b0; op1 = 32'd100; op2 = 32'd7; div_req = 1'b1;
`ifdef DIV_ISSUE_TIMEOUT_EN
        tcyc = -1;
        for (int c = 0; c < 80 && tcyc < 0; c++) begin
            @(negedge clk);
            if (timeout === 1'b1) tcyc = c;
            else tick();
        end
        chk("tmo_cycle", 32'(tcyc), 32'd41);
        div_req = 1'b0;
        cc = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            if (dif.div_cancel_o === 1'b1) cc++;
            tick();
        end
        chk("tmo_cancel_cycles", 32'(cc), 32'd3);
        chk("tmo_sticky", 32'(timeout), 32'd1);
        div_req = 1'b1;
        tick();
`else
        tcyc = 0;
        repeat (60) tick();
        chk("no_tmo_flag", 32'(timeout), 32'd0);
        chk("no_tmo_still_stalled", 32'(stall), 32'd1);
`endif

        // Reset in the middle of BUSY.
        we0 = n_we;
        repeat (15) tick();
        chk("pre_rst_busy_stall", 32'(stall), 32'd1);
        rst = 1'b1; div_req = 1'b0;
        tick();
        chk("mid_rst_start", 32'(dif.div_start_o), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        chk("mid_rst_op1", dif.div_opdata1_o, 32'd0);
        chk("mid_rst_tmo", 32'(timeout), 32'd0);
        rst = 1'b0; dv_never = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_we", 32'(n_we - we0), 32'd0);

        run_div("after_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

endmodule
